// File: rtl/sdram_frame_addr_gen_if.sv
// Burst request bundle between a frame address generator and its FIFO/SDRAM side.
// master: the generator; slave: the environment (bank switcher, FIFO, SDRAM controller).
interface sdram_frame_addr_gen_if #(
  parameter int unsigned BANK_W = 2,
  parameter int unsigned OFS_W  = 20,
  parameter int unsigned LEN_W  = 9
);
  logic                      load;
  logic [BANK_W-1:0]         bank;
  logic                      fifo_ready;
  logic                      burst_req;
  logic [BANK_W+OFS_W-1:0]   burst_addr;
  logic [LEN_W-1:0]          burst_len;
  logic                      burst_ack;
  logic                      burst_done;
  logic                      frame_done;
  logic                      busy;

  modport master (
    input  load, bank, fifo_ready, burst_ack, burst_done,
    output burst_req, burst_addr, burst_len, frame_done, busy
  );

  modport slave (
    output load, bank, fifo_ready, burst_ack, burst_done,
    input  burst_req, burst_addr, burst_len, frame_done, busy
  );
endinterface

// File: rtl/sdram_frame_addr_gen.sv
// Per-port SDRAM frame address generator: on load, walks one frame of a bank
// in bursts of up to BURST_LEN words, then holds frame_done until the next load.
module sdram_frame_addr_gen #(
  parameter int unsigned BANK_W      = 2,
  parameter int unsigned OFS_W       = 20,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned LEN_W       = 9
) (
  input  logic clk,
  input  logic rst,
  sdram_frame_addr_gen_if.master bus
);
  localparam int unsigned WD_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, REQ, XFER, DONE} state_t;

  state_t                  state, state_nxt;
  logic [BANK_W-1:0]       cur_bank, cur_bank_nxt;
  logic [BANK_W-1:0]       pend_bank, pend_bank_nxt;
  logic                    load_pend, load_pend_nxt;
  logic [WD_W-1:0]         words_done, words_done_nxt, words_sum;
  logic                    req_nxt, fd_nxt, busy_nxt;
  logic [BANK_W+OFS_W-1:0] addr_nxt;
  logic [LEN_W-1:0]        len_nxt, len;
  logic [31:0]             rem;
  logic                    restart, last;

  assign rem       = FRAME_WORDS - 32'(words_done);
  assign len       = (rem < BURST_LEN) ? LEN_W'(rem) : LEN_W'(BURST_LEN);
  assign words_sum = words_done + WD_W'(bus.burst_len);
  assign last      = (32'(words_sum) == FRAME_WORDS);
  // A load arriving with burst_done is applied directly, beating any older pending load
  assign restart   = bus.load || load_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.load) state_nxt = WAIT_DATA;
      WAIT_DATA:  if (!bus.load && bus.fifo_ready) state_nxt = REQ;
      REQ:        if (bus.burst_ack) state_nxt = XFER;
      XFER:       if (bus.burst_done) state_nxt = (!restart && last) ? DONE : WAIT_DATA;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_bank_nxt   = cur_bank;
    pend_bank_nxt  = pend_bank;
    load_pend_nxt  = load_pend;
    words_done_nxt = words_done;
    req_nxt        = bus.burst_req;
    addr_nxt       = bus.burst_addr;
    len_nxt        = bus.burst_len;
    fd_nxt         = bus.frame_done;
    case (state)
      IDLE, DONE, WAIT_DATA: begin
        if (bus.load) begin
          cur_bank_nxt   = bus.bank;
          words_done_nxt = '0;
          fd_nxt         = 1'b0;
          load_pend_nxt  = 1'b0;
        end else if (state == WAIT_DATA && bus.fifo_ready) begin
          req_nxt  = 1'b1;
          addr_nxt = {cur_bank, OFS_W'(words_done)};
          len_nxt  = len;
        end
      end
      REQ: begin
        if (bus.load) begin
          load_pend_nxt = 1'b1;
          pend_bank_nxt = bus.bank;
        end
        if (bus.burst_ack) req_nxt = 1'b0;
      end
      XFER: begin
        if (bus.burst_done) begin
          if (restart) begin
            cur_bank_nxt   = bus.load ? bus.bank : pend_bank;
            words_done_nxt = '0;
            load_pend_nxt  = 1'b0;
          end else begin
            words_done_nxt = words_sum;
            fd_nxt         = last;
          end
        end else if (bus.load) begin
          load_pend_nxt = 1'b1;
          pend_bank_nxt = bus.bank;
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt == REQ) || (state_nxt == XFER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_bank       <= '0;
      pend_bank      <= '0;
      load_pend      <= 1'b0;
      words_done     <= '0;
      bus.burst_req  <= 1'b0;
      bus.burst_addr <= '0;
      bus.burst_len  <= '0;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      cur_bank       <= cur_bank_nxt;
      pend_bank      <= pend_bank_nxt;
      load_pend      <= load_pend_nxt;
      words_done     <= words_done_nxt;
      bus.burst_req  <= req_nxt;
      bus.burst_addr <= addr_nxt;
      bus.burst_len  <= len_nxt;
      bus.frame_done <= fd_nxt;
      bus.busy       <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_sdram_frame_addr_gen.sv
// Bench for sdram_frame_addr_gen: three instances (600, 256 and 1 word frames)
// share the SDRAM-side stimulus; expected bursts come from a frame model queue.
module tb_sdram_frame_addr_gen;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned OFS_W  = 20;
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned BL     = 256;
  localparam int unsigned AW     = BANK_W + OFS_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        load;
  logic [BANK_W-1:0] bank;
  logic              fifo_ready, burst_ack, burst_done;

  logic              req  [3];
  logic [AW-1:0]     addr [3];
  logic [LEN_W-1:0]  blen [3];
  logic              fd   [3];
  logic              bsy  [3];

  always #5 clk = ~clk;

  sdram_frame_addr_gen_if #(.BANK_W(BANK_W), .OFS_W(OFS_W), .LEN_W(LEN_W)) ifa (), ifb (), ifc ();

  assign ifa.load = load[0];  assign ifb.load = load[1];  assign ifc.load = load[2];
  assign ifa.bank = bank;     assign ifb.bank = bank;     assign ifc.bank = bank;
  assign ifa.fifo_ready = fifo_ready; assign ifb.fifo_ready = fifo_ready; assign ifc.fifo_ready = fifo_ready;
  assign ifa.burst_ack  = burst_ack;  assign ifb.burst_ack  = burst_ack;  assign ifc.burst_ack  = burst_ack;
  assign ifa.burst_done = burst_done; assign ifb.burst_done = burst_done; assign ifc.burst_done = burst_done;

  assign req[0] = ifa.burst_req;  assign addr[0] = ifa.burst_addr; assign blen[0] = ifa.burst_len;
  assign fd[0]  = ifa.frame_done; assign bsy[0]  = ifa.busy;
  assign req[1] = ifb.burst_req;  assign addr[1] = ifb.burst_addr; assign blen[1] = ifb.burst_len;
  assign fd[1]  = ifb.frame_done; assign bsy[1]  = ifb.busy;
  assign req[2] = ifc.burst_req;  assign addr[2] = ifc.burst_addr; assign blen[2] = ifc.burst_len;
  assign fd[2]  = ifc.frame_done; assign bsy[2]  = ifc.busy;

  sdram_frame_addr_gen #(.BANK_W(BANK_W), .OFS_W(OFS_W), .FRAME_WORDS(600), .BURST_LEN(BL), .LEN_W(LEN_W))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  sdram_frame_addr_gen #(.BANK_W(BANK_W), .OFS_W(OFS_W), .FRAME_WORDS(256), .BURST_LEN(BL), .LEN_W(LEN_W))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  sdram_frame_addr_gen #(.BANK_W(BANK_W), .OFS_W(OFS_W), .FRAME_WORDS(1), .BURST_LEN(BL), .LEN_W(LEN_W))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] len;
  } burst_t;

  typedef struct {
    int sel; int bank; int gap; int ackw; int donew; int nb; int last;
  } vec_t;

  burst_t      exp_q[$];
  int unsigned fw [3] = '{600, 256, 1};
  int          total = 0;
  int          bad   = 0;
  int          last_len = 0;
  vec_t        vecs [5];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame model: the burst sequence a fresh load of bank b should produce
  task automatic model_load(input int sel, input logic [BANK_W-1:0] b);
    int unsigned w = 0;
    int unsigned n;
    exp_q.delete();
    while (w < fw[sel]) begin
      n = (fw[sel] - w < BL) ? fw[sel] - w : BL;
      exp_q.push_back('{addr: {b, OFS_W'(w)}, len: LEN_W'(n)});
      w += n;
    end
  endtask

  task automatic pulse_load(input int sel, input logic [BANK_W-1:0] b);
    load[sel] = 1'b1;
    bank      = b;
    model_load(sel, b);
    tick();
    load = '0;
    chk("fd_clear_on_load", 32'(fd[sel]), 0);
  endtask

  task automatic serve_req(input int sel, input int ackw, output bit ok);
    int     cyc = 0;
    burst_t e;
    ok = 1'b0;
    while (!req[sel] && cyc < 64) begin
      tick();
      cyc++;
    end
    if (!req[sel]) begin
      chk("req_timeout", 32'(req[sel]), 1);
      return;
    end
    ok = 1'b1;
    last_len = int'(blen[sel]);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow: got burst addr=%0h len=%0d, expected none", addr[sel], blen[sel]);
      e = '{addr: addr[sel], len: blen[sel]};
    end else begin
      e = exp_q.pop_front();
      chk("burst_addr", 32'(addr[sel]), 32'(e.addr));
      chk("burst_len", 32'(blen[sel]), 32'(e.len));
    end
    chk("busy_req", 32'(bsy[sel]), 1);
    repeat (ackw) begin
      tick();
      chk("req_hold", 32'(req[sel]), 1);
      chk("addr_hold", 32'(addr[sel]), 32'(e.addr));
    end
    burst_ack = 1'b1;
    tick();
    burst_ack = 1'b0;
    chk("req_drop", 32'(req[sel]), 0);
  endtask

  task automatic serve_done(input int sel, input int donew);
    repeat (donew) tick();
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("frame_done_after_burst", 32'(fd[sel]), (exp_q.size() == 0) ? 1 : 0);
  endtask

  task automatic serve_frame(input int sel, input int ackw, input int donew, input int exp_nb, input int exp_last);
    int nb = 0;
    bit ok;
    while (!fd[sel] && nb < 8) begin
      serve_req(sel, ackw, ok);
      if (!ok) break;
      serve_done(sel, donew);
      nb++;
    end
    chk("n_bursts", nb, exp_nb);
    chk("last_len", last_len, exp_last);
    chk("sb_empty", exp_q.size(), 0);
    tick();
    tick();
    chk("fd_hold", 32'(fd[sel]), 1);
    chk("busy_idle", 32'(bsy[sel]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = '{sel: 0, bank: 2, gap: 0,  ackw: 2, donew: 2, nb: 3, last: 88};
    vecs[1] = '{sel: 0, bank: 3, gap: 0,  ackw: 0, donew: 0, nb: 3, last: 88};
    vecs[2] = '{sel: 0, bank: 1, gap: 10, ackw: 5, donew: 1, nb: 3, last: 88};
    vecs[3] = '{sel: 1, bank: 1, gap: 0,  ackw: 1, donew: 1, nb: 1, last: 256};
    vecs[4] = '{sel: 2, bank: 3, gap: 0,  ackw: 1, donew: 1, nb: 1, last: 1};

    rst = 1'b1; load = '0; bank = '0; fifo_ready = 1'b1; burst_ack = 1'b0; burst_done = 1'b0;
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      chk("rst_req", 32'(req[s]), 0);
      chk("rst_addr", 32'(addr[s]), 0);
      chk("rst_len", 32'(blen[s]), 0);
      chk("rst_fd", 32'(fd[s]), 0);
      chk("rst_busy", 32'(bsy[s]), 0);
    end
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("idle_no_req", 32'(req[0]), 0);
    end

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].gap > 0) fifo_ready = 1'b0;
      pulse_load(vecs[i].sel, BANK_W'(vecs[i].bank));
      repeat (vecs[i].gap) begin
        tick();
        chk("bp_no_req", 32'(req[vecs[i].sel]), 0);
        chk("bp_busy", 32'(bsy[vecs[i].sel]), 0);
      end
      fifo_ready = 1'b1;
      serve_frame(vecs[i].sel, vecs[i].ackw, vecs[i].donew, vecs[i].nb, vecs[i].last);
    end

    // Loads during XFER of the second burst: burst completes, newest bank wins
    pulse_load(0, 2'd2);
    serve_req(0, 1, ok);
    serve_done(0, 1);
    serve_req(0, 1, ok);
    pulse_load(0, 2'd0);
    pulse_load(0, 2'd1);
    serve_done(0, 2);
    serve_frame(0, 1, 1, 3, 88);

    // Load coincident with the final burst_done: load wins, frame_done stays low
    pulse_load(0, 2'd0);
    serve_req(0, 1, ok);
    serve_done(0, 1);
    serve_req(0, 1, ok);
    serve_done(0, 1);
    serve_req(0, 1, ok);
    load[0] = 1'b1; bank = 2'd2; burst_done = 1'b1;
    model_load(0, 2'd2);
    tick();
    load = '0; burst_done = 1'b0;
    chk("coincident_load_fd", 32'(fd[0]), 0);
    serve_frame(0, 1, 1, 3, 88);

    // Asynchronous reset with a request outstanding
    pulse_load(0, 2'd1);
    tick();
    chk("req_before_rst", 32'(req[0]), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(req[0]), 0);
    chk("async_rst_busy", 32'(bsy[0]), 0);
    chk("async_rst_addr", 32'(addr[0]), 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    repeat (3) begin
      tick();
      chk("post_rst_no_req", 32'(req[0]), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
